// File: rtl/imem_loader_pkg.sv
// Shared types and sizing for the instruction-memory loader.
package imem_loader_pkg;

    localparam int unsigned DEF_DEPTH      = 64;
    localparam int unsigned DEF_ADDR_W     = 6;
    localparam int unsigned DEF_CNT_W      = 7;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = 32;

    typedef enum logic [2:0] {
        HDR   = 3'd0,
        DATA  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready channel feeding the loader.
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/imem_loader_instr_ram.sv
// Instruction RAM: one synchronous write port, one combinational fetch port; never cleared.
module instr_ram
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed big-endian word stream into instruction RAM and
// holds the processor in reset until the whole image has been written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    imem_loader_if.slave      rx,
    input  logic [ADDR_W-1:0] instrindex,
    output logic [WORD_W-1:0] instr,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_error,
    output logic [CNT_W-1:0]  words_loaded
);

    localparam int unsigned     BCNT_W    = $clog2(BYTES_PER_WORD);
    localparam logic [BYTE_W-1:0] DEPTH_B = BYTE_W'(DEPTH);
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_WORD - 1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  n_words;
    logic [CNT_W-1:0]  ptr;
    logic [CNT_W-1:0]  ptr_inc;
    logic [BCNT_W-1:0] bytecnt;
    logic [WORD_W-1:0] word;
    logic              accept;
    logic              we;

    assign accept  = rx.rx_valid & rx.rx_ready;
    assign ptr_inc = ptr + CNT_W'(1);
    assign we      = (state == WRITE);

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            HDR: begin
                if (accept) begin
                    if (rx.rx_data == '0)          state_next = DONE;
                    else if (rx.rx_data > DEPTH_B) state_next = ERR;
                    else                           state_next = DATA;
                end
            end
            DATA: begin
                if (accept && (bytecnt == LAST_BYTE)) state_next = WRITE;
            end
            WRITE: begin
                state_next = (ptr_inc == n_words) ? DONE : DATA;
            end
            DONE:    state_next = DONE;
            ERR:     state_next = ERR;
            default: state_next = HDR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= HDR;
        else       state <= state_next;
    end

    // Datapath and status outputs; status is decoded from the next state so it
    // changes on the same edge as the state itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_words      <= '0;
            ptr          <= '0;
            bytecnt      <= '0;
            word         <= '0;
            words_loaded <= '0;
            rx.rx_ready  <= 1'b1;
            cpu_reset    <= 1'b1;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
        end else begin
            rx.rx_ready <= (state_next == HDR) || (state_next == DATA);
            cpu_reset   <= (state_next != DONE);
            load_done   <= (state_next == DONE);
            load_error  <= (state_next == ERR);
            case (state)
                HDR: begin
                    if (accept) begin
                        n_words <= CNT_W'(rx.rx_data);
                        ptr     <= '0;
                        bytecnt <= '0;
                    end
                end
                DATA: begin
                    if (accept) begin
                        word    <= {word[WORD_W-BYTE_W-1:0], rx.rx_data};
                        bytecnt <= bytecnt + BCNT_W'(1);
                    end
                end
                WRITE: begin
                    ptr          <= ptr_inc;
                    words_loaded <= words_loaded + CNT_W'(1);
                    bytecnt      <= '0;
                end
                default: ;
            endcase
        end
    end

    instr_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (ptr[ADDR_W-1:0]),
        .wdata (word),
        .raddr (instrindex),
        .rdata (instr)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Directed-plus-random bench for imem_loader with a word-level RAM model.
module tb_imem_loader;

    localparam int DEPTH = 64;

    logic        clk;
    logic        reset;
    logic [5:0]  instrindex;
    logic [31:0] instr;
    logic        cpu_reset;
    logic        load_done;
    logic        load_error;
    logic [6:0]  words_loaded;

    imem_loader_if rx();

    imem_loader dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .instrindex   (instrindex),
        .instr        (instr),
        .cpu_reset    (cpu_reset),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          errors;
    int          not_ready;
    logic [31:0] model_ram [DEPTH];
    bit          model_known [DEPTH];
    logic [31:0] stim [$];
    logic [31:0] old63;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        rx.rx_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Offer one byte after an idle gap; returns at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            rx.rx_valid = 1'b0;
            rx.rx_data  = 8'($urandom);
            if (rx.rx_ready !== 1'b1) not_ready++;
            @(negedge clk);
        end
        rx.rx_valid = 1'b1;
        rx.rx_data  = b;
        t = 0;
        while (rx.rx_ready !== 1'b1 && t < 20) begin
            not_ready++;
            @(negedge clk);
            t++;
        end
        if (t >= 20) chk("accept_timeout", 32'(rx.rx_ready), 32'(1));
        @(negedge clk);
        rx.rx_valid = 1'b0;
    endtask

    // Header n, then stim[0..n-1] MSB first; stops after stop_bytes data bytes if >= 0.
    task automatic load(input int n, input int maxgap, input int stop_bytes);
        int sent;
        bit stopped;
        sent      = 0;
        stopped   = 1'b0;
        not_ready = 0;
        send_byte(8'(n), 0);
        if (n >= 1 && n <= DEPTH) begin
            for (int w = 0; w < n; w++) begin
                for (int k = 0; k < 4; k++) begin
                    if (stop_bytes >= 0 && sent == stop_bytes) stopped = 1'b1;
                    if (stopped) break;
                    send_byte(8'(stim[w] >> (8 * (3 - k))),
                              (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
                    sent++;
                end
                if (stopped) break;
                model_ram[w]   = stim[w];
                model_known[w] = 1'b1;
            end
            if (!stopped && rx.rx_ready !== 1'b1) not_ready++;
        end
    endtask

    task automatic check_ram(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            if (model_known[i]) begin
                instrindex = 6'(i);
                #1;
                chk(tag, instr, model_ram[i]);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        checks      = 0;
        errors      = 0;
        not_ready   = 0;
        reset       = 1'b1;
        rx.rx_valid = 1'b0;
        rx.rx_data  = 8'h00;
        instrindex  = 6'd0;
        for (int i = 0; i < DEPTH; i++) begin
            model_ram[i]   = 32'h0;
            model_known[i] = 1'b0;
        end
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_ready",  32'(rx.rx_ready), 32'(1));
        chk("rst_cpu",    32'(cpu_reset),   32'(1));
        chk("rst_done",   32'(load_done),   32'(0));
        chk("rst_err",    32'(load_error),  32'(0));
        chk("rst_words",  32'(words_loaded), 32'(0));
        reset = 1'b0;
        @(negedge clk);

        // Three-word program, no gaps
        stim = {};
        stim.push_back(32'h20010005);
        stim.push_back(32'h20020005);
        stim.push_back(32'h08000004);
        load(3, 0, -1);
        chk("n3_write_ready", 32'(rx.rx_ready), 32'(0));
        chk("n3_write_cpu",   32'(cpu_reset),   32'(1));
        chk("n3_write_done",  32'(load_done),   32'(0));
        @(negedge clk);
        chk("n3_cpu",   32'(cpu_reset),    32'(0));
        chk("n3_done",  32'(load_done),    32'(1));
        chk("n3_words", 32'(words_loaded), 32'(3));
        check_ram("n3_ram");
        instrindex = 6'd0;
        #1;
        chk("n3_fetch_pc0", instr, 32'h20010005);
        @(negedge clk);
        rx.rx_valid = 1'b1;
        rx.rx_data  = 8'hFF;
        @(negedge clk);
        chk("n3_done_ready", 32'(rx.rx_ready),   32'(0));
        chk("n3_done_words", 32'(words_loaded), 32'(3));
        rx.rx_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("done_rst_cpu",  32'(cpu_reset), 32'(1));
        chk("done_rst_done", 32'(load_done), 32'(0));
        @(negedge clk);
        reset = 1'b0;

        // Empty image
        load(0, 0, -1);
        chk("n0_done",  32'(load_done),  32'(1));
        chk("n0_cpu",   32'(cpu_reset),  32'(0));
        chk("n0_ready", 32'(rx.rx_ready), 32'(0));
        chk("n0_err",   32'(load_error), 32'(0));
        rx.rx_valid = 1'b1;
        rx.rx_data  = 8'h01;
        @(negedge clk);
        chk("n0_ignored_ready", 32'(rx.rx_ready),   32'(0));
        chk("n0_ignored_words", 32'(words_loaded), 32'(0));
        rx.rx_valid = 1'b0;
        check_ram("n0_ram");
        do_reset();

        // Oversized header, held for 100 cycles
        load(65, 0, -1);
        for (int c = 0; c < 100; c++) begin
            rx.rx_valid = 1'b1;
            rx.rx_data  = 8'($urandom);
            chk("n65_hold", {28'h0, load_error, rx.rx_ready, cpu_reset, load_done}, 32'hA);
            @(negedge clk);
        end
        rx.rx_valid = 1'b0;
        chk("n65_words", 32'(words_loaded), 32'(0));
        check_ram("n65_ram");
        do_reset();
        load(int'($urandom_range(255, 66)), 0, -1);
        chk("nbig_err", 32'(load_error), 32'(1));
        chk("nbig_cpu", 32'(cpu_reset),  32'(1));
        do_reset();

        // Two words gap-free, then two fresh words with random gaps
        stim = {};
        stim.push_back($urandom);
        stim.push_back($urandom);
        load(2, 0, -1);
        @(negedge clk);
        chk("n2_done", 32'(load_done), 32'(1));
        check_ram("n2_ram");
        do_reset();
        stim = {};
        stim.push_back($urandom);
        stim.push_back($urandom);
        load(2, 5, -1);
        chk("gap_not_ready_cycles", 32'(not_ready), 32'(2));
        @(negedge clk);
        chk("gap_done",  32'(load_done),    32'(1));
        chk("gap_words", 32'(words_loaded), 32'(2));
        check_ram("gap_ram");
        do_reset();

        // Reset in the middle of a four-word load
        stim = {};
        for (int i = 0; i < 4; i++) stim.push_back($urandom);
        load(4, 0, 9);
        chk("mid_words_before", 32'(words_loaded), 32'(2));
        #2 reset = 1'b1;
        #1;
        chk("mid_words", 32'(words_loaded), 32'(0));
        chk("mid_cpu",   32'(cpu_reset),    32'(1));
        chk("mid_ready", 32'(rx.rx_ready),  32'(1));
        @(negedge clk);
        reset = 1'b0;
        check_ram("mid_ram");
        stim = {};
        stim.push_back($urandom);
        load(1, 0, -1);
        @(negedge clk);
        chk("reload_words", 32'(words_loaded), 32'(1));
        check_ram("reload_ram");
        do_reset();

        // Full-depth loads: random image, then word i at index i
        stim = {};
        for (int i = 0; i < DEPTH; i++) stim.push_back($urandom);
        load(64, 0, -1);
        @(negedge clk);
        chk("full_rand_words", 32'(words_loaded), 32'(64));
        do_reset();
        stim = {};
        for (int i = 0; i < DEPTH; i++) stim.push_back(32'(i));
        old63      = model_ram[63];
        instrindex = 6'd63;
        load(64, 0, -1);
        chk("full_last_write_old", instr, old63);
        @(negedge clk);
        chk("full_last_write_new", instr, 32'h3F);
        chk("full_words", 32'(words_loaded), 32'(64));
        chk("full_done",  32'(load_done),    32'(1));
        chk("full_cpu",   32'(cpu_reset),    32'(0));
        check_ram("full_ram");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
